// File: rtl/page_uploader.sv
// page_uploader: UART (8N1) receiver plus frame parser that writes 12-bit RGB
// pixels of one comic page into the page image memory.
// Frame: 0xA5, page, PIX_PER_PAGE x {hi, lo}, 0x5A.
module page_uploader #(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 115200,
    parameter int PIX_PER_PAGE = 307200,
    parameter int PAGE_MAX     = 4,
    parameter int TIMEOUT_CYC  = 10_000_000
) (
    input  logic        clk100mhz,
    input  logic        sys_rst_n,
    input  logic        uart_rx,
    output logic        wr_en,
    output logic [9:0]  wr_page,
    output logic [18:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int DIV  = CLK_HZ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int BCW  = $clog2(DIV + 1);
    localparam int TCW  = $clog2(TIMEOUT_CYC + 1);

    localparam logic [BCW-1:0] BAUD_FULL  = BCW'(DIV - 1);
    localparam logic [BCW-1:0] BAUD_HALF  = BCW'(HALF - 1);
    localparam logic [TCW-1:0] TO_LAST    = TCW'(TIMEOUT_CYC - 1);
    localparam logic [7:0]     PAGE_MAX_B = 8'(PAGE_MAX);
    localparam logic [18:0]    PIX_LAST   = 19'(PIX_PER_PAGE - 1);
    localparam logic [7:0]     HDR_BYTE   = 8'hA5;
    localparam logic [7:0]     TRL_BYTE   = 8'h5A;

    // ------------------------------------------------------------------
    // Serial receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t      r_rx_state;
    rx_state_t      w_rx_state_next;
    logic           r_rx_sync1;
    logic           r_rx_sync2;
    logic           r_rx_prev;
    logic [BCW-1:0] r_baud_cnt;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_rx_shift;
    logic           r_rx_valid;
    logic           r_rx_ferr;

    logic           w_fall;
    logic           w_bit_tick;
    logic           w_shift;
    logic           w_rx_valid_next;
    logic           w_rx_ferr_next;

    // Falling edge on the synchronised line marks a possible start bit.
    assign w_fall = r_rx_prev & ~r_rx_sync2;

    // The start bit is checked half a bit in; every later sample is one bit apart.
    assign w_bit_tick = (r_rx_state == RX_START) ? (r_baud_cnt == BAUD_HALF)
                                                 : (r_baud_cnt == BAUD_FULL);

    // Synchroniser and edge-detect history for the asynchronous serial input.
    always_ff @(posedge clk100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_sync1 <= 1'b1;
            r_rx_sync2 <= 1'b1;
            r_rx_prev  <= 1'b1;
        end else begin
            r_rx_sync1 <= uart_rx;
            r_rx_sync2 <= r_rx_sync1;
            r_rx_prev  <= r_rx_sync2;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    // Receiver next state: a high line at the start check is a glitch.
    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_fall) w_rx_state_next = RX_START;
            RX_START: if (w_bit_tick) w_rx_state_next = r_rx_sync2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_bit_tick && (r_bit_cnt == 3'd7)) w_rx_state_next = RX_STOP;
            RX_STOP:  if (w_bit_tick) w_rx_state_next = RX_IDLE;
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    // Receiver outputs: data shift enable and the stop-bit verdict.
    always_comb begin
        w_shift         = (r_rx_state == RX_DATA) && w_bit_tick;
        w_rx_valid_next = (r_rx_state == RX_STOP) && w_bit_tick &&  r_rx_sync2;
        w_rx_ferr_next  = (r_rx_state == RX_STOP) && w_bit_tick && !r_rx_sync2;
    end

    // Receiver datapath: bit timing, LSB-first shift register, strobes.
    always_ff @(posedge clk100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_valid <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            if ((r_rx_state == RX_IDLE) || w_bit_tick) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (r_rx_state != RX_DATA) begin
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_shift) begin
                r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
            end
            r_rx_valid <= w_rx_valid_next;
            r_rx_ferr  <= w_rx_ferr_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {S_IDLE, S_PAGE, S_PIX_HI, S_PIX_LO, S_TRAIL} state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [TCW-1:0] r_to_cnt;
    logic [18:0]    r_pix_idx;
    logic [3:0]     r_hi;
    logic           r_wr_en;
    logic [9:0]     r_wr_page;
    logic [18:0]    r_wr_addr;
    logic [11:0]    r_wr_data;
    logic           r_busy;
    logic           r_done;
    logic           r_err;

    logic           w_timeout;
    logic           w_abort;
    logic           w_busy_set;
    logic           w_page_load;
    logic           w_hi_load;
    logic           w_pix_write;
    logic           w_done_next;
    logic           w_err_next;

    // A silent link inside a frame, or a broken stop bit, kills the frame.
    assign w_timeout = (r_to_cnt == TO_LAST) && !r_rx_valid;
    assign w_abort   = (r_state != S_IDLE) && (r_rx_ferr || w_timeout);

    // Parser state register.
    always_ff @(posedge clk100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Parser next state: moves only on a received byte, or on abort.
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = S_IDLE;
        end else if (r_rx_valid) begin
            case (r_state)
                S_IDLE:   if (r_rx_shift == HDR_BYTE) w_state_next = S_PAGE;
                S_PAGE:   w_state_next = (r_rx_shift <= PAGE_MAX_B) ? S_PIX_HI : S_IDLE;
                S_PIX_HI: w_state_next = S_PIX_LO;
                S_PIX_LO: w_state_next = (r_pix_idx == PIX_LAST) ? S_TRAIL : S_PIX_HI;
                S_TRAIL:  w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Parser outputs: decide which action the current byte triggers.
    always_comb begin
        w_busy_set  = 1'b0;
        w_page_load = 1'b0;
        w_hi_load   = 1'b0;
        w_pix_write = 1'b0;
        w_done_next = 1'b0;
        w_err_next  = 1'b0;
        if (w_abort) begin
            w_err_next = 1'b1;
        end else if (r_rx_valid) begin
            case (r_state)
                S_IDLE:   w_busy_set = (r_rx_shift == HDR_BYTE);
                S_PAGE: begin
                    if (r_rx_shift <= PAGE_MAX_B) w_page_load = 1'b1;
                    else                          w_err_next  = 1'b1;
                end
                S_PIX_HI: w_hi_load   = 1'b1;
                S_PIX_LO: w_pix_write = 1'b1;
                S_TRAIL: begin
                    if (r_rx_shift == TRL_BYTE) w_done_next = 1'b1;
                    else                        w_err_next  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Parser datapath: registered strobes, write bus, pixel index, link timer.
    always_ff @(posedge clk100mhz or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_to_cnt  <= '0;
            r_pix_idx <= '0;
            r_hi      <= '0;
            r_wr_en   <= 1'b0;
            r_wr_page <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) || r_rx_valid) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_page_load) begin
                r_wr_page <= {2'b00, r_rx_shift};
                r_wr_addr <= '0;
                r_pix_idx <= '0;
            end
            if (w_hi_load) begin
                r_hi <= r_rx_shift[3:0];
            end
            if (w_pix_write) begin
                r_wr_addr <= r_pix_idx;
                r_wr_data <= {r_hi, r_rx_shift};
                r_pix_idx <= r_pix_idx + 1'b1;
            end
            if (w_done_next || w_err_next) begin
                r_busy <= 1'b0;
            end else if (w_busy_set) begin
                r_busy <= 1'b1;
            end
            r_wr_en <= w_pix_write;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign wr_en   = r_wr_en;
    assign wr_page = r_wr_page;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = r_busy;
    assign done    = r_done;
    assign err     = r_err;

endmodule
